spw_state_poller: RTL and testbench

- Avalon-MM read master that initiates periodic reads of a 3-bit link-state PIO slave (for example the SpaceWire CURRENTSTATE port) and tracks state changes in hardware.
- Holds the last sampled state, counts transitions, and raises a sticky interrupt on every change, so software no longer has to poll the PIO.
- Sits between the PIO slave's s1 interface and the Nios/control logic.

---
 rtl/spw_state_poller.sv | 129 ++++++++++++
 tb/tb_spw_state_poller.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spw_state_poller.sv
// Avalon-MM read master that periodically samples a link-state PIO and reports
// state changes through a saturating counter, a one-cycle strobe and a sticky irq.
module spw_state_poller #(
    parameter int unsigned POLL_DIV     = 1000,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [1:0]  POLL_ADDR    = 2'd0,
    parameter int unsigned DATA_W       = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] state_out,
    output logic              state_valid,
    output logic              change_pulse,
    output logic [15:0]       change_count,
    output logic              irq,
    input  logic              irq_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAP
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(POLL_DIV - 1);
    localparam logic [2:0]  LAT_INIT = 3'(READ_LATENCY);

    state_t            state, state_next;
    logic [15:0]       div_q, div_next;
    logic [2:0]        lat_q, lat_next;
    logic [DATA_W-1:0] sample_q, sample_next;
    logic              change;
    logic              readdata_unused;

    assign avm_address     = POLL_ADDR;
    assign readdata_unused = ^avm_readdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            div_q    <= '0;
            lat_q    <= '0;
            sample_q <= '0;
        end else begin
            state    <= state_next;
            div_q    <= div_next;
            lat_q    <= lat_next;
            sample_q <= sample_next;
        end
    end

    // The divider leaves IDLE on the cycle its incremented value reaches
    // POLL_DIV-1, so IDLE lasts POLL_DIV-1 cycles between transactions.
    always_comb begin
        state_next  = state;
        div_next    = div_q;
        lat_next    = lat_q;
        sample_next = sample_q;
        case (state)
            S_IDLE: begin
                if (!enable) begin
                    div_next = '0;
                end else if (div_q + 16'd1 == DIV_LAST) begin
                    div_next   = '0;
                    state_next = S_REQ;
                end else begin
                    div_next = div_q + 16'd1;
                end
            end
            S_REQ: begin
                if (!avm_waitrequest) begin
                    lat_next   = LAT_INIT;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                lat_next = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    sample_next = avm_readdata[DATA_W-1:0];
                    state_next  = S_CAP;
                end
            end
            S_CAP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign change       = (state == S_CAP) && state_valid && (sample_q != state_out);
    assign avm_read     = (state == S_REQ) && !reset;
    assign change_pulse = change && !reset;

    // irq is set-dominant: a change in the same cycle as irq_ack keeps it high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_out    <= '0;
            state_valid  <= 1'b0;
            change_count <= '0;
            irq          <= 1'b0;
        end else begin
            if (state == S_CAP) begin
                if (!state_valid) begin
                    state_out   <= sample_q;
                    state_valid <= 1'b1;
                end else if (change) begin
                    state_out <= sample_q;
                    if (change_count != 16'hFFFF) begin
                        change_count <= change_count + 16'd1;
                    end
                end
            end
            if (change) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spw_state_poller.sv
// Self-checking bench for spw_state_poller: a behavioural Avalon slave plus a
// transaction-level model of the sampled state, change counter and irq.
module tb_spw_state_poller;

    localparam int         POLL_DIV     = 4;
    localparam int         READ_LATENCY = 1;
    localparam int         DATA_W       = 3;
    localparam logic [1:0] POLL_ADDR    = 2'd1;
    // IDLE lasts POLL_DIV-1 cycles, then one REQ, READ_LATENCY WAIT and one CAP cycle.
    localparam int         PERIOD       = (POLL_DIV - 1) + 1 + READ_LATENCY + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [1:0]        avm_address;
    logic              avm_read;
    logic              avm_waitrequest = 1'b0;
    logic [31:0]       avm_readdata = '0;
    logic [DATA_W-1:0] state_out;
    logic              state_valid;
    logic              change_pulse;
    logic [15:0]       change_count;
    logic              irq;
    logic              irq_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    spw_state_poller #(
        .POLL_DIV    (POLL_DIV),
        .READ_LATENCY(READ_LATENCY),
        .POLL_ADDR   (POLL_ADDR),
        .DATA_W      (DATA_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .state_out      (state_out),
        .state_valid    (state_valid),
        .change_pulse   (change_pulse),
        .change_count   (change_count),
        .irq            (irq),
        .irq_ack        (irq_ack)
    );

    always #5 clk = ~clk;

    // Behavioural slave and bus monitor; readdata carries random garbage except
    // on the single cycle READ_LATENCY after acceptance.
    int                cycle = 0, accepts = 0, read_cycles = 0, pulses = 0;
    int                addr_bad = 0, last_accept = -1, pend = 0;
    int                stall_cfg = 0, stall_left = 0;
    logic [DATA_W-1:0] slave_value = '0;

    always @(negedge clk) begin
        cycle++;
        if (change_pulse) pulses++;
        avm_readdata = $urandom();
        if (pend > 0) begin
            pend--;
            if (pend == 0) avm_readdata[DATA_W-1:0] = slave_value;
        end
        if (avm_read) begin
            read_cycles++;
            if (avm_address != POLL_ADDR) addr_bad++;
            if (stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                avm_waitrequest = 1'b0;
                accepts++;
                last_accept = cycle;
                pend = READ_LATENCY;
            end
        end else begin
            avm_waitrequest = 1'b0;
            stall_left = stall_cfg;
        end
    end

    // Reference model of what software should observe after each sample.
    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_state = '0;
    logic [15:0]       m_count = '0;
    logic              m_irq = 1'b0;

    task automatic model_reset();
        m_valid = 1'b0; m_state = '0; m_count = '0; m_irq = 1'b0;
    endtask

    task automatic model_step(input logic [DATA_W-1:0] v, input bit ack, output bit exp_pulse);
        exp_pulse = 1'b0;
        if (!m_valid) begin
            m_valid = 1'b1;
            m_state = v;
            if (ack) m_irq = 1'b0;
        end else if (v != m_state) begin
            m_state = v;
            exp_pulse = 1'b1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            m_irq = 1'b1;
        end else if (ack) begin
            m_irq = 1'b0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_accept(input int prev, output bit ok);
        for (int i = 0; i < 200; i++) begin
            if (accepts != prev) break;
            tick(1);
        end
        ok = (accepts != prev);
    endtask

    task automatic quiesce();
        enable = 1'b0;
        irq_ack = 1'b0;
        tick(12);
    endtask

    // Runs one poll and returns in the first IDLE cycle after CAP.
    task automatic poll_once(input logic [DATA_W-1:0] v, input int stalls, input bit ack_cap,
                             output bit ok, output logic cap_pulse, output int acc_cycle);
        int prev;
        prev = accepts;
        slave_value = v;
        stall_cfg = stalls;
        enable = 1'b1;
        wait_accept(prev, ok);
        acc_cycle = last_accept;
        tick(READ_LATENCY + 1);
        cap_pulse = change_pulse;
        if (ack_cap) irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        tick(2);
        checks++; if (avm_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read: got %0b want 0", avm_read); end
        checks++; if (state_out !== '0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", state_out); end
        checks++; if (state_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", state_valid); end
        checks++; if (change_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0h want 0", change_count); end
        checks++; if (irq !== 1'b0 || change_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq_pulse: got %0b/%0b want 0/0", irq, change_pulse); end
        checks++; if (avm_address !== POLL_ADDR) begin errors++; $display("[TB] FAIL reset_addr: got %0d want %0d", avm_address, POLL_ADDR); end
        enable = 1'b0;
        reset = 1'b0;
        model_reset();
        tick(2);
    endtask

    task automatic test_basic_poll();
        bit ok, ep; logic cp; int c0, c1, rc;
        quiesce();
        poll_once(3'd2, 0, 1'b0, ok, cp, c0);
        model_step(3'd2, 1'b0, ep);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_accept: got timeout want read"); end
        checks++; if (state_out !== 3'd2) begin errors++; $display("[TB] FAIL basic_state: got %0d want 2", state_out); end
        checks++; if (state_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %0b want 1", state_valid); end
        checks++; if (cp !== ep || irq !== 1'b0 || change_count !== 16'd0) begin errors++; $display("[TB] FAIL basic_first_event: got pulse=%0b irq=%0b cnt=%0d want 0/0/0", cp, irq, change_count); end
        rc = read_cycles;
        poll_once(3'd2, 0, 1'b0, ok, cp, c1);
        model_step(3'd2, 1'b0, ep);
        checks++; if (c1 - c0 !== PERIOD) begin errors++; $display("[TB] FAIL basic_period: got %0d want %0d", c1 - c0, PERIOD); end
        checks++; if (read_cycles - rc !== 1) begin errors++; $display("[TB] FAIL basic_read_len: got %0d want 1", read_cycles - rc); end
        checks++; if (addr_bad !== 0) begin errors++; $display("[TB] FAIL basic_addr: got %0d bad want 0", addr_bad); end
    endtask

    task automatic test_change_detect();
        bit ok, ep; logic cp; int c, p0;
        p0 = pulses;
        poll_once(3'd5, 0, 1'b0, ok, cp, c);
        model_step(3'd5, 1'b0, ep);
        checks++; if (cp !== 1'b1 || pulses - p0 !== 1) begin errors++; $display("[TB] FAIL change_pulse: got %0b x%0d want 1 x1", cp, pulses - p0); end
        checks++; if (state_out !== 3'd5 || change_count !== 16'd1 || irq !== 1'b1) begin errors++; $display("[TB] FAIL change_outputs: got st=%0d cnt=%0d irq=%0b want 5/1/1", state_out, change_count, irq); end
        p0 = pulses;
        poll_once(3'd5, 0, 1'b0, ok, cp, c);
        model_step(3'd5, 1'b0, ep);
        checks++; if (pulses - p0 !== 0 || change_count !== 16'd1 || state_out !== 3'd5) begin errors++; $display("[TB] FAIL change_repeat: got pulses=%0d cnt=%0d st=%0d want 0/1/5", pulses - p0, change_count, state_out); end
    endtask

    task automatic test_waitrequest();
        bit ok, ep; logic cp; int c, rc, a0; logic [DATA_W-1:0] v;
        v = ~m_state;
        rc = read_cycles;
        a0 = accepts;
        poll_once(v, 3, 1'b0, ok, cp, c);
        model_step(v, 1'b0, ep);
        checks++; if (read_cycles - rc !== 4) begin errors++; $display("[TB] FAIL stall_read_len: got %0d want 4", read_cycles - rc); end
        checks++; if (accepts - a0 !== 1) begin errors++; $display("[TB] FAIL stall_accepts: got %0d want 1", accepts - a0); end
        checks++; if (state_out !== m_state || cp !== ep) begin errors++; $display("[TB] FAIL stall_sample: got st=%0d pulse=%0b want %0d/%0b", state_out, cp, m_state, ep); end
        checks++; if (addr_bad !== 0) begin errors++; $display("[TB] FAIL stall_addr: got %0d bad want 0", addr_bad); end
    endtask

    task automatic test_irq_race();
        bit ok, ep; logic cp; int c; logic [DATA_W-1:0] v;
        quiesce();
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        m_irq = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear: got %0b want 0", irq); end
        v = ~m_state;
        poll_once(v, 0, 1'b1, ok, cp, c);
        model_step(v, 1'b1, ep);
        checks++; if (irq !== 1'b1 || cp !== 1'b1) begin errors++; $display("[TB] FAIL irq_race: got irq=%0b pulse=%0b want 1/1", irq, cp); end
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        m_irq = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_ack_next: got %0b want 0", irq); end
    endtask

    task automatic test_random();
        bit ok, ep, ack; logic cp; int c, p0, st; logic [DATA_W-1:0] v;
        quiesce();
        for (int i = 0; i < 40; i++) begin
            v = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            if ($urandom_range(0, 2) == 0) v = m_state;
            st = $urandom_range(0, 3);
            ack = 1'($urandom_range(0, 1));
            p0 = pulses;
            poll_once(v, st, ack, ok, cp, c);
            model_step(v, ack, ep);
            checks++; if (!ok || cp !== ep || pulses - p0 !== int'(ep)) begin errors++; $display("[TB] FAIL rand_pulse[%0d]: got ok=%0b pulse=%0b x%0d want %0b", i, ok, cp, pulses - p0, ep); end
            checks++; if (state_out !== m_state || change_count !== m_count || irq !== m_irq || state_valid !== m_valid) begin
                errors++; $display("[TB] FAIL rand_state[%0d]: got st=%0d cnt=%0d irq=%0b vld=%0b want %0d/%0d/%0b/%0b", i, state_out, change_count, irq, state_valid, m_state, m_count, m_irq, m_valid);
            end
        end
    endtask

    task automatic test_saturation();
        bit ok, ep; logic cp; int c; logic [DATA_W-1:0] v;
        quiesce();
        force dut.change_count = 16'hFFFD;
        tick(1);
        release dut.change_count;
        m_count = 16'hFFFD;
        tick(1);
        checks++; if (change_count !== 16'hFFFD) begin errors++; $display("[TB] FAIL sat_preload: got %0h want fffd", change_count); end
        for (int i = 0; i < 3; i++) begin
            v = ~m_state;
            poll_once(v, 0, 1'b0, ok, cp, c);
            model_step(v, 1'b0, ep);
            checks++; if (cp !== 1'b1 || change_count !== m_count || irq !== 1'b1) begin errors++; $display("[TB] FAIL sat_step[%0d]: got pulse=%0b cnt=%0h irq=%0b want 1/%0h/1", i, cp, change_count, irq, m_count); end
        end
        checks++; if (change_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_hold: got %0h want ffff", change_count); end
    endtask

    task automatic test_disable_mid();
        bit ok, ep; int prev, a1, rc; logic [DATA_W-1:0] v;
        quiesce();
        v = ~m_state;
        stall_cfg = 5;
        slave_value = v;
        prev = accepts;
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (avm_read) break;
            tick(1);
        end
        checks++; if (avm_read !== 1'b1) begin errors++; $display("[TB] FAIL dis_req_seen: got %0b want 1", avm_read); end
        tick(1);
        enable = 1'b0;
        wait_accept(prev, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL dis_complete: got timeout want accept"); end
        tick(READ_LATENCY + 2);
        model_step(v, 1'b0, ep);
        checks++; if (state_out !== m_state || change_count !== m_count) begin errors++; $display("[TB] FAIL dis_sample: got st=%0d cnt=%0d want %0d/%0d", state_out, change_count, m_state, m_count); end
        a1 = accepts;
        rc = read_cycles;
        tick(40);
        checks++; if (accepts !== a1 || read_cycles !== rc) begin errors++; $display("[TB] FAIL dis_quiet: got %0d extra read cycles want 0", read_cycles - rc); end
    endtask

    task automatic test_reset_abort();
        bit ok, ep; logic cp; int c, prev;
        quiesce();
        stall_cfg = 4;
        slave_value = 3'd3;
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (avm_read) break;
            tick(1);
        end
        reset = 1'b1;
        #1;
        checks++; if (avm_read !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_read: got %0b want 0", avm_read); end
        enable = 1'b0;
        tick(2);
        reset = 1'b0;
        model_reset();
        poll_once(3'd1, 0, 1'b0, ok, cp, c);
        model_step(3'd1, 1'b0, ep);
        poll_once(3'd6, 0, 1'b0, ok, cp, c);
        model_step(3'd6, 1'b0, ep);
        checks++; if (change_count !== 16'd1 || irq !== 1'b1) begin errors++; $display("[TB] FAIL rst_rebuild: got cnt=%0d irq=%0b want 1/1", change_count, irq); end
        stall_cfg = 0;
        slave_value = 3'd3;
        prev = accepts;
        wait_accept(prev, ok);
        tick(1);
        reset = 1'b1;
        #1;
        checks++; if (avm_read !== 1'b0 || state_out !== '0 || state_valid !== 1'b0 || change_count !== 16'd0 || irq !== 1'b0 || change_pulse !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_wait_outputs: got rd=%0b st=%0d vld=%0b cnt=%0d irq=%0b pulse=%0b want all 0", avm_read, state_out, state_valid, change_count, irq, change_pulse);
        end
        tick(2);
        reset = 1'b0;
        model_reset();
        poll_once(3'd4, 0, 1'b0, ok, cp, c);
        model_step(3'd4, 1'b0, ep);
        checks++; if (cp !== 1'b0 || state_valid !== 1'b1 || state_out !== 3'd4 || change_count !== 16'd0 || irq !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_first_sample: got pulse=%0b vld=%0b st=%0d cnt=%0d irq=%0b want 0/1/4/0/0", cp, state_valid, state_out, change_count, irq);
        end
    endtask

    initial begin
        test_reset();
        test_basic_poll();
        test_change_detect();
        test_waitrequest();
        test_irq_race();
        test_random();
        test_saturation();
        test_disable_mid();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
